// File: rtl/xs_sdr_rom_arbiter.sv
// Round-robin arbiter that shares one SDRAM ROM read port among NREQ tile-fetch engines.
// It holds one pending request per engine and keeps a single read outstanding, with a timeout.
module xs_sdr_rom_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 25,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_ram,
  input  logic               RESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_rdy,
  output logic [15:0]        req_data,
  output logic [AW-1:0]      sdr_addr,
  output logic               sdr_req,
  input  logic               sdr_rdy,
  input  logic [15:0]        sdr_data,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          state_r;
  logic [NREQ-1:0] pend_r;
  logic [AW-1:0]   pend_addr_r [NREQ];
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   gnt_r;
  logic [CW-1:0]   cnt_r;

  logic            pick_valid_s;
  logic [IW-1:0]   pick_idx_s;
  logic [AW-1:0]   pick_addr_s;
  logic [IW-1:0]   rr_next_s;
  logic            grant_s;
  int              scan_s;

  // Round-robin scan from rr_ptr; the downward loop leaves the nearest pending index last.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    pick_addr_s  = '0;
    scan_s       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_s = int'(rr_ptr_r) + k;
      if (scan_s >= NREQ) begin
        scan_s = scan_s - NREQ;
      end else begin
        scan_s = scan_s;
      end
      if (pend_r[scan_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = IW'(scan_s);
        pick_addr_s  = pend_addr_r[scan_s];
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
    if (pick_idx_s == IW'(NREQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = pick_idx_s + IW'(1);
    end
    grant_s = (state_r == ST_IDLE) && pick_valid_s;
  end

  // Pending slots: a fresh pulse always wins over the grant that clears the slot.
  always_ff @(posedge clk_ram) begin
    if (RESET) begin
      pend_r <= '0;
      for (int i = 0; i < NREQ; i++) begin
        pend_addr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          pend_r[i]      <= 1'b1;
          pend_addr_r[i] <= req_addr[i*AW +: AW];
        end else if (grant_s && (pick_idx_s == IW'(i))) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

  // Transaction FSM with registered SDRAM strobe, delivery pulse and status flags.
  always_ff @(posedge clk_ram) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      gnt_r       <= '0;
      cnt_r       <= '0;
      sdr_addr    <= '0;
      sdr_req     <= 1'b0;
      req_rdy     <= '0;
      req_data    <= 16'h0000;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sdr_req <= 1'b0;
      req_rdy <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            gnt_r    <= pick_idx_s;
            sdr_addr <= pick_addr_s;
            sdr_req  <= 1'b1;
            rr_ptr_r <= rr_next_s;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdr_rdy) begin
            req_data <= sdr_data;
            req_rdy  <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_r;
            cnt_r    <= '0;
            busy     <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            // Abandoned read is dropped; the engine re-requests on its next tile.
            timeout_err <= 1'b1;
            cnt_r       <= '0;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
// Directed self-checking bench for xs_sdr_rom_arbiter (NREQ=3, AW=25, TIMEOUT=64).
module tb_xs_sdr_rom_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 25;

  logic               clk_ram = 1'b0;
  logic               RESET;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_rdy;
  logic [15:0]        req_data;
  logic [AW-1:0]      sdr_addr;
  logic               sdr_req;
  logic               sdr_rdy;
  logic [15:0]        sdr_data;
  logic               busy;
  logic               timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  xs_sdr_rom_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(64)) dut (
    .clk_ram    (clk_ram),
    .RESET      (RESET),
    .req        (req),
    .req_addr   (req_addr),
    .req_rdy    (req_rdy),
    .req_data   (req_data),
    .sdr_addr   (sdr_addr),
    .sdr_req    (sdr_req),
    .sdr_rdy    (sdr_rdy),
    .sdr_data   (sdr_data),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_ram = ~clk_ram;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] r, input logic [24:0] a0, input logic [24:0] a1,
                       input logic [24:0] a2);
    req      = r;
    req_addr = {a2, a1, a0};
    tick();
    req = 3'b000;
  endtask

  task automatic wait_issue(input string tag, input logic [24:0] exp_addr);
    int n;
    n = 0;
    while (!sdr_req && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_issue"}, {31'd0, sdr_req}, 32'd1);
    check_val({tag, "_addr"}, {7'd0, sdr_addr}, {7'd0, exp_addr});
  endtask

  task automatic respond(input string tag, input logic [15:0] data, input logic [2:0] exp_rdy);
    sdr_rdy  = 1'b1;
    sdr_data = data;
    tick();
    sdr_rdy = 1'b0;
    check_val({tag, "_rdy"}, {29'd0, req_rdy}, {29'd0, exp_rdy});
    check_val({tag, "_data"}, {16'd0, req_data}, {16'd0, data});
  endtask

  task automatic serve(input string tag, input logic [15:0] data, input logic [24:0] exp_addr,
                       input logic [2:0] exp_rdy);
    wait_issue(tag, exp_addr);
    respond(tag, data, exp_rdy);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | sdr_req | (|req_rdy);
    end
    check_val(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic seen_rdy;
    RESET    = 1'b1;
    req      = 3'b000;
    req_addr = '0;
    sdr_rdy  = 1'b0;
    sdr_data = 16'h0000;
    do_reset();
    check_val("rst_req_rdy", {29'd0, req_rdy}, 32'd0);
    check_val("rst_req_data", {16'd0, req_data}, 32'd0);
    check_val("rst_sdr_addr", {7'd0, sdr_addr}, 32'd0);
    check_val("rst_sdr_req", {31'd0, sdr_req}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_timeout", {31'd0, timeout_err}, 32'd0);

    // 1: single request, exact two-cycle issue latency
    pulse(3'b010, 25'h0, 25'h0A01234, 25'h0);
    check_val("t1_early", {31'd0, sdr_req}, 32'd0);
    tick();
    check_val("t1_sdr_req", {31'd0, sdr_req}, 32'd1);
    check_val("t1_sdr_addr", {7'd0, sdr_addr}, 32'h0A01234);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    respond("t1", 16'hBEEF, 3'b010);
    check_val("t1_idle", {31'd0, busy}, 32'd0);
    tick();
    check_val("t1_rdy_pulse", {29'd0, req_rdy}, 32'd0);
    check_val("t1_data_hold", {16'd0, req_data}, 32'h0000BEEF);

    // 2: all three at once, then wrap to 0
    do_reset();
    pulse(3'b111, 25'h100, 25'h101, 25'h102);
    serve("t2a", 16'h1000, 25'h100, 3'b001);
    serve("t2b", 16'h1001, 25'h101, 3'b010);
    serve("t2c", 16'h1002, 25'h102, 3'b100);
    pulse(3'b011, 25'h110, 25'h111, 25'h0);
    serve("t2d", 16'h1010, 25'h110, 3'b001);
    serve("t2e", 16'h1011, 25'h111, 3'b010);

    // 3: latest address wins while another read is outstanding
    do_reset();
    pulse(3'b001, 25'h200, 25'h0, 25'h0);
    wait_issue("t3a", 25'h200);
    pulse(3'b100, 25'h0, 25'h0, 25'h2AA);
    pulse(3'b100, 25'h0, 25'h0, 25'h2BB);
    check_val("t3_addr_stable", {7'd0, sdr_addr}, 32'h200);
    respond("t3a", 16'h2000, 3'b001);
    serve("t3b", 16'h2BB0, 25'h2BB, 3'b100);
    expect_quiet("t3_single_read", 6);

    // 4: timeout, next pending granted, stray rdy ignored
    do_reset();
    pulse(3'b011, 25'h300, 25'h301, 25'h0);
    wait_issue("t4a", 25'h300);
    seen_rdy = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      seen_rdy = seen_rdy | (|req_rdy);
    end
    check_val("t4_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    seen_rdy = seen_rdy | (|req_rdy);
    check_val("t4_timeout", {31'd0, timeout_err}, 32'd1);
    check_val("t4_no_rdy", {31'd0, seen_rdy}, 32'd0);
    serve("t4b", 16'h1111, 25'h301, 3'b010);
    sdr_rdy  = 1'b1;
    sdr_data = 16'hDEAD;
    tick();
    sdr_rdy = 1'b0;
    check_val("t4_stray_rdy", {29'd0, req_rdy}, 32'd0);
    check_val("t4_stray_data", {16'd0, req_data}, 32'h1111);
    check_val("t4_sticky", {31'd0, timeout_err}, 32'd1);

    // 5: requester 0 re-requests during its own read
    do_reset();
    pulse(3'b011, 25'h500, 25'h501, 25'h0);
    wait_issue("t5a", 25'h500);
    pulse(3'b001, 25'h5A0, 25'h0, 25'h0);
    respond("t5a", 16'h5000, 3'b001);
    serve("t5b", 16'h5001, 25'h501, 3'b010);
    serve("t5c", 16'h50A0, 25'h5A0, 3'b001);

    // 6: reset in WAIT discards the read and the pending queue
    do_reset();
    pulse(3'b101, 25'h600, 25'h0, 25'h602);
    wait_issue("t6a", 25'h600);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_val("t6_busy", {31'd0, busy}, 32'd0);
    check_val("t6_sdr_req", {31'd0, sdr_req}, 32'd0);
    check_val("t6_sdr_addr", {7'd0, sdr_addr}, 32'd0);
    check_val("t6_req_rdy", {29'd0, req_rdy}, 32'd0);
    tick();
    sdr_rdy  = 1'b1;
    sdr_data = 16'h6666;
    tick();
    sdr_rdy = 1'b0;
    check_val("t6_late_rdy", {29'd0, req_rdy}, 32'd0);
    check_val("t6_late_data", {16'd0, req_data}, 32'd0);
    expect_quiet("t6_pend_clear", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
